// File: rtl/fdiv_ieee754_seq.sv
// fdiv_ieee754_seq: iterative restoring IEEE-754 divider, one quotient bit per clock.
// Subnormals flush to zero and NaN inputs are not handled. Results truncate by default.
// Defining FDIV_ROUND_NEAREST_EN adds a guard bit, a sticky bit and a round-to-nearest-even
// cycle (ROUND) after NORM.
module fdiv_ieee754_seq #(
   parameter int  EXP_W  = 8,
   parameter int  FRAC_W = 23,
   localparam int W      = 1 + EXP_W + FRAC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         div_by_zero
);
   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam int EMAX = 2**EXP_W - 1;
   localparam int ITER = FRAC_W + 2;
`ifdef FDIV_ROUND_NEAREST_EN
   localparam int QW = ITER + 1;   // one extra quotient bit serves as the guard bit
`else
   localparam int QW = ITER;
`endif
   localparam int CW = $clog2(QW);
   localparam int MW = FRAC_W + 1; // mantissa with hidden bit
   localparam int RW = FRAC_W + 2; // partial remainder
   localparam int EW = EXP_W + 2;  // signed exponent arithmetic

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_NORM, S_ROUND, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [RW-1:0]        rem, rem_nxt;
   logic [MW-1:0]        fb;
   logic [QW-1:0]        q;
   logic [EXP_W-1:0]     ea, eb;
   logic                 sign, dz, rem_ge, n;
   logic [W-1:0]         res;
   logic signed [EW-1:0] e_c;

   logic [EXP_W-1:0]     a_exp, b_exp;
   logic                 a_zero, b_zero, accept;
   logic [MW-1:0]        fa_in, fb_in;

   assign a_exp       = a[W-2 -: EXP_W];
   assign b_exp       = b[W-2 -: EXP_W];
   assign a_zero      = (a_exp == '0);
   assign b_zero      = (b_exp == '0);
   assign fa_in       = a_zero ? '0 : {1'b1, a[FRAC_W-1:0]};
   assign fb_in       = b_zero ? '0 : {1'b1, b[FRAC_W-1:0]};
   assign in_ready    = (state == S_IDLE);
   assign out_valid   = (state == S_DONE);
   assign accept      = in_valid & in_ready;
   assign out         = res;
   assign div_by_zero = dz;

   // Assemble a result word with underflow flush and overflow-to-infinity.
   function automatic logic [W-1:0] pack(input logic s, input logic signed [EW-1:0] e,
                                         input logic [FRAC_W-1:0] f);
      if (e <= 0)         pack = '0;
      else if (e >= EMAX) pack = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      else                pack = {s, e[EXP_W-1:0], f};
   endfunction

   // One restoring step plus the normalisation terms derived from the quotient.
   always_comb begin
      rem_ge  = (rem >= RW'(fb));
      rem_nxt = (rem_ge ? rem - RW'(fb) : rem) << 1;
      n       = q[QW-1];
      e_c     = EW'(ea) - EW'(eb) + EW'(BIAS) - EW'(!n);
   end

`ifdef FDIV_ROUND_NEAREST_EN
   logic signed [EW-1:0] e_r, e_rnd;
   logic [MW-1:0]        mant_r, mant_c;
   logic [MW:0]          sum;
   logic                 grd, stk, grd_c, stk_c, inc;
   logic [FRAC_W-1:0]    frac_rnd;

   // Guard/sticky extraction and round-to-nearest-even with carry-out renormalisation.
   always_comb begin
      mant_c   = n ? q[QW-1:2] : q[QW-2:1];
      grd_c    = n ? q[1] : q[0];
      stk_c    = (n & q[0]) | (|rem);
      inc      = grd & (stk | mant_r[0]);
      sum      = {1'b0, mant_r} + (MW+1)'(inc);
      e_rnd    = e_r + EW'(sum[MW]);
      frac_rnd = sum[MW] ? '0 : sum[FRAC_W-1:0];
   end
`else
   logic [FRAC_W-1:0] frac_t;

   // Drop the leading one; keep the next FRAC_W quotient bits (truncation).
   always_comb begin
      frac_t = n ? q[QW-2:1] : q[QW-3:0];
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = (a_zero | b_zero) ? S_DONE : S_CALC;
         S_CALC:  if (cnt == '0) state_nxt = S_NORM;
`ifdef FDIV_ROUND_NEAREST_EN
         S_NORM:  state_nxt = S_ROUND;
`else
         S_NORM:  state_nxt = S_DONE;
`endif
         S_ROUND: state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: capture at accept, iterate in CALC, form the result in NORM/ROUND.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: datapath registers are reset too, because out must read zero straight out of reset.
      if (!rst_n) begin
         cnt  <= '0;
         rem  <= '0;
         fb   <= '0;
         q    <= '0;
         ea   <= '0;
         eb   <= '0;
         sign <= 1'b0;
         dz   <= 1'b0;
         res  <= '0;
`ifdef FDIV_ROUND_NEAREST_EN
         e_r    <= '0;
         mant_r <= '0;
         grd    <= 1'b0;
         stk    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               sign <= a[W-1] ^ b[W-1];
               ea   <= a_exp;
               eb   <= b_exp;
               rem  <= RW'(fa_in);
               fb   <= fb_in;
               q    <= '0;
               cnt  <= CW'(QW-1);
               dz   <= b_zero;
               if (b_zero)      res <= {a[W-1] ^ b[W-1], {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               else if (a_zero) res <= '0;
            end
            S_CALC: begin
               q   <= {q[QW-2:0], rem_ge};
               rem <= rem_nxt;
               cnt <= cnt - 1'b1;
            end
`ifdef FDIV_ROUND_NEAREST_EN
            S_NORM: begin
               e_r    <= e_c;
               mant_r <= mant_c;
               grd    <= grd_c;
               stk    <= stk_c;
            end
            S_ROUND: res <= pack(sign, e_rnd, frac_rnd);
`else
            S_NORM:  res <= pack(sign, e_c, frac_t);
`endif
            S_DONE: if (out_ready) dz <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fdiv_ieee754_seq.sv
// Self-checking bench for fdiv_ieee754_seq: directed vector table, randomized operands against
// an arithmetic reference model, and hand-written handshake / reset sequences.
// Honours FDIV_ROUND_NEAREST_EN the same way as the design.
module tb_fdiv_ieee754_seq;
`ifdef FDIV_ROUND_NEAREST_EN
   localparam int LAT = 29;
   localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
   localparam int LAT = 27;
   localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, div_by_zero;
   logic [31:0] a, b, out_w;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic        dz;
      int          lat;
   } vec_t;

   fdiv_ieee754_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .out(out_w), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: exact quotient of the mantissas, scaled to 24 significant bits.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic d);
      logic        s;
      int          ea, eb, e;
      longint      ma, mb, num, qq, rr;
      logic [22:0] fr;
      s  = x[31] ^ y[31];
      ea = int'(x[30:23]);
      eb = int'(y[30:23]);
      d  = 1'b0;
      if (eb == 0) begin
         r = {s, 8'hFF, 23'h0};
         d = 1'b1;
         return;
      end
      if (ea == 0) begin
         r = '0;
         return;
      end
      ma  = longint'(x[22:0]) + (longint'(1) << 23);
      mb  = longint'(y[22:0]) + (longint'(1) << 23);
      e   = ea - eb + 127;
      num = ma << 23;
      if (ma < mb) begin
         num = num << 1;
         e   = e - 1;
      end
      qq = num / mb;
      rr = num % mb;
`ifdef FDIV_ROUND_NEAREST_EN
      if (2 * rr > mb || (2 * rr == mb && qq[0])) qq = qq + 1;
      if (qq == (longint'(1) << 24)) begin
         qq = longint'(1) << 23;
         e  = e + 1;
      end
`endif
      fr = qq[22:0];
      if (e <= 0)        r = '0;
      else if (e >= 255) r = {s, 8'hFF, 23'h0};
      else               r = {s, 8'(e), fr};
   endfunction

   // Drive a request and return on the falling edge after the accept edge (edge 1).
   task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout actual=0 required=1");
      end
      in_valid = 1'b1;
      a = ta;
      b = tb_v;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   // Count edges since accept until out_valid is seen; -1 if it never comes.
   task automatic wait_result(input int n0, output int lat);
      int n = n0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      lat = out_valid ? n : -1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         output logic [31:0] r, output logic d, output int lat);
      start_op(ta, tb_v);
      wait_result(1, lat);
      r = out_w;
      d = div_by_zero;
      handshake();
   endtask

   initial begin
      vec_t        vecs[9];
      logic [31:0] r, v, xa, xb, mr;
      logic        d, md;
      int          lat, hits;
      logic [7:0]  ex;

      vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT};
      vecs[1] = '{32'h3F800000, 32'h40400000, THIRD,        1'b0, LAT};
      vecs[2] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1};
      vecs[3] = '{32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1};
      vecs[4] = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, LAT};
      vecs[5] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, LAT};
      vecs[6] = '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1};
      vecs[7] = '{32'h41200000, 32'h40A00000, 32'h40000000, 1'b0, LAT};
      vecs[8] = '{32'hC0000000, 32'h40000000, 32'hBF800000, 1'b0, LAT};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #2;
      check("reset_in_ready",  32'(in_ready),    32'd1);
      check("reset_out_valid", 32'(out_valid),   32'd0);
      check("reset_out",       out_w,            32'd0);
      check("reset_dz",        32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, r, d, lat);
         check($sformatf("vec%0d_out", i), r, vecs[i].q);
         check($sformatf("vec%0d_dz", i),  32'(d), 32'(vecs[i].dz));
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_release", i), 32'(out_valid), 32'd0);
      end

      // Randomized operands against the reference model
      for (int i = 0; i < 40; i++) begin
         ex = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
         xa = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
         ex = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
         xb = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
         model(xa, xb, mr, md);
         run_op(xa, xb, r, d, lat);
         check($sformatf("rnd%0d_out %h/%h", i, xa, xb), r, mr);
         check($sformatf("rnd%0d_dz", i), 32'(d), 32'(md));
      end

      // Hold out_ready low for 5 cycles in DONE; in_valid pulses there are ignored
      start_op(32'h3F800000, 32'h00000000);
      wait_result(1, lat);
      check("hold_lat", 32'(lat), 32'd1);
      v = out_w;
      check("hold_value", v, 32'h7F800000);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = 32'h40400000; b = 32'h3F800000;
         @(negedge clk);
         check($sformatf("hold%0d_out", i), out_w, v);
         check($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
         check($sformatf("hold%0d_dz", i), 32'(div_by_zero), 32'd1);
      end
      in_valid = 1'b0;
      handshake();
      check("post_hs_valid",    32'(out_valid),   32'd0);
      check("post_hs_dz",       32'(div_by_zero), 32'd0);
      check("post_hs_out_held", out_w,            v);
      check("post_hs_in_ready", 32'(in_ready),    32'd1);

      // in_valid pulsed during CALC is ignored
      start_op(32'h40C00000, 32'h40000000);
      repeat (4) @(negedge clk);
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h40400000;
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(6, lat);
      check("busy_pulse_out", out_w, 32'h40400000);
      check("busy_pulse_lat", 32'(lat), 32'(LAT));
      handshake();

      // Reset mid-CALC: outputs clear at once and no stale result appears
      start_op(32'h40C00000, 32'h3F800000);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out",      out_w,            32'd0);
      check("midrst_valid",    32'(out_valid),   32'd0);
      check("midrst_in_ready", 32'(in_ready),    32'd1);
      check("midrst_dz",       32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      repeat (35) begin
         @(negedge clk);
         if (out_valid) hits++;
      end
      check("midrst_no_stale", 32'(hits), 32'd0);
      run_op(32'h41200000, 32'h40A00000, r, d, lat);
      check("after_rst_out", r, 32'h40000000);
      check("after_rst_lat", 32'(lat), 32'(LAT));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
